// File: rtl/cpu_pkg.sv
// Shared types and constants for the execute/writeback slice of the CPU.
// The writeback entry struct is the payload stored in the writeback FIFO.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    // Bit positions inside the architectural {N, Z, C} flag vector
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              cout;
        logic              zero;
        logic [REG_AW-1:0] rd;
        logic              setflags;
    } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with synchronous active-high reset.
// Besides the head entry it exposes the raw storage and a per-slot valid
// vector so that the wrapper can scan every pending entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [WIDTH-1:0]              wr_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [WIDTH-1:0]              rd_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0][WIDTH-1:0]   entries,
    output logic [DEPTH-1:0]              entry_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 count_q, count_d;
    logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
    logic                          push;
    logic                          pop;
    logic [AW-1:0]                 slot_offset;

    // Full/empty come from registered occupancy only, so neither handshake
    // output has a combinational path from the inputs.
    assign wr_ready    = (count_q != CW'(DEPTH));
    assign rd_valid    = (count_q != '0);
    assign push        = wr_valid & wr_ready;
    assign pop         = rd_ready & rd_valid;
    assign rd_data     = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign entries     = mem_q;

    // Next-state for storage, pointers and occupancy; pointers wrap modulo DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A slot is occupied when its distance from the read pointer is below the occupancy.
    always_comb begin
        slot_offset = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_offset    = AW'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, slot_offset} < count_q);
        end
    end

    // State register; storage is cleared too so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: buffers ALU results in a small FIFO, drains them to the
// register-file write port and maintains the architectural {N, Z, C} flags.
// Optional macro N_FLAG_EN adds storage for the negative flag; without it
// flags[2] is tied low.
module alu_writeback #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int REG_AW = cpu_pkg::REG_AW,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_result,
    input  logic                     in_cout,
    input  logic                     in_zero,
    input  logic [REG_AW-1:0]        in_rd,
    input  logic                     in_setflags,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [REG_AW-1:0]        wb_addr,
    output logic [DATA_W-1:0]        wb_data,
    output logic [2:0]               flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [2**REG_AW-1:0]     busy_rd_mask
);

    import cpu_pkg::*;

    localparam int ENTRY_W = $bits(wb_entry_t);

    wb_entry_t                       in_entry;
    wb_entry_t                       head;
    wb_entry_t                       scan_entry;
    logic [ENTRY_W-1:0]              fifo_rd_data;
    logic [DEPTH-1:0][ENTRY_W-1:0]   fifo_entries;
    logic [DEPTH-1:0]                fifo_entry_valid;
    logic                            fifo_rd_valid;
    logic                            pop;
    logic                            c_q, c_d;
    logic                            z_q, z_d;

    assign in_entry.result   = in_result;
    assign in_entry.cout     = in_cout;
    assign in_entry.zero     = in_zero;
    assign in_entry.rd       = in_rd;
    assign in_entry.setflags = in_setflags;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (in_valid),
        .wr_ready    (in_ready),
        .wr_data     (in_entry),
        .rd_valid    (fifo_rd_valid),
        .rd_ready    (wb_ready & ~rst),
        .rd_data     (fifo_rd_data),
        .count       (count),
        .entries     (fifo_entries),
        .entry_valid (fifo_entry_valid)
    );

    // The write is suppressed while reset is held so a pending entry cannot
    // reach the register file on the same edge that discards it.
    assign head     = fifo_rd_data;
    assign wb_valid = fifo_rd_valid & ~rst;
    assign wb_addr  = head.rd;
    assign wb_data  = head.result;
    assign pop      = wb_valid & wb_ready;

    // Mark every register that still has a queued write so the hazard unit can stall readers.
    always_comb begin
        busy_rd_mask = '0;
        scan_entry   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_entry = fifo_entries[i];
            if (fifo_entry_valid[i]) begin
                busy_rd_mask[scan_entry.rd] = 1'b1;
            end
        end
    end

    // Carry and zero flags follow the draining entry only when it requests a flag update.
    always_comb begin
        c_d = c_q;
        z_d = z_q;
        if (pop && head.setflags) begin
            c_d = head.cout;
            z_d = head.zero;
        end
    end

    // Carry/zero flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
        end
    end

`ifdef N_FLAG_EN
    logic n_q, n_d;

    // Negative flag takes the sign bit of the draining flag-setting result.
    always_comb begin
        n_d = n_q;
        if (pop && head.setflags) begin
            n_d = head.result[DATA_W-1];
        end
    end

    // Negative flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q <= 1'b0;
        end else begin
            n_q <= n_d;
        end
    end

    // Assemble the visible flag vector.
    always_comb begin
        flags         = '0;
        flags[FLAG_C] = c_q;
        flags[FLAG_Z] = z_q;
        flags[FLAG_N] = n_q;
    end
`else
    // Assemble the visible flag vector; there is no negative flag in this build.
    always_comb begin
        flags         = '0;
        flags[FLAG_C] = c_q;
        flags[FLAG_Z] = z_q;
        flags[FLAG_N] = 1'b0;
    end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback. A queue-based reference model tracks
// the pending writes and the architectural flags; outputs are sampled on the
// falling edge and inputs are driven right after sampling.
module tb_alu_writeback;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int DEPTH  = 2;

    typedef struct {
        logic [DATA_W-1:0] result;
        bit                cout;
        bit                zero;
        logic [REG_AW-1:0] rd;
        bit                setflags;
    } model_entry_t;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_result;
    logic                    in_cout;
    logic                    in_zero;
    logic [REG_AW-1:0]       in_rd;
    logic                    in_setflags;
    logic                    wb_valid;
    logic                    wb_ready;
    logic [REG_AW-1:0]       wb_addr;
    logic [DATA_W-1:0]       wb_data;
    logic [2:0]              flags;
    logic [$clog2(DEPTH):0]  count;
    logic [2**REG_AW-1:0]    busy_rd_mask;

    int checks = 0;
    int errors = 0;

    model_entry_t model_q[$];
    bit           model_c, model_z, model_n;

    alu_writeback #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_cout      (in_cout),
        .in_zero      (in_zero),
        .in_rd        (in_rd),
        .in_setflags  (in_setflags),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flags        (flags),
        .count        (count),
        .busy_rd_mask (busy_rd_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags as seen architecturally; N only exists in the N_FLAG_EN build.
    function automatic logic [2:0] model_flags();
`ifdef N_FLAG_EN
        return {model_n, model_z, model_c};
`else
        return {1'b0, model_z, model_c};
`endif
    endfunction

    // Registers that still have a queued write.
    function automatic logic [2**REG_AW-1:0] model_mask();
        logic [2**REG_AW-1:0] m;
        m = '0;
        foreach (model_q[i]) m[model_q[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic drive(input bit v, input logic [DATA_W-1:0] r, input bit c, input bit z,
                         input logic [REG_AW-1:0] rd, input bit sf);
        in_valid    = v;
        in_result   = r;
        in_cout     = c;
        in_zero     = z;
        in_rd       = rd;
        in_setflags = sf;
    endtask

    // Advance one clock: the model applies this cycle's handshakes, then we
    // wait for the edge and settle on the following falling edge.
    task automatic tick();
        model_entry_t e;
        bit do_push, do_pop;
        if (rst) begin
            model_q.delete();
            model_c = 0;
            model_z = 0;
            model_n = 0;
        end else begin
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = wb_ready && (model_q.size() > 0);
            if (do_pop) begin
                e = model_q.pop_front();
                if (e.setflags) begin
                    model_c = e.cout;
                    model_z = e.zero;
                    model_n = e.result[DATA_W-1];
                end
            end
            if (do_push) begin
                e.result   = in_result;
                e.cout     = in_cout;
                e.zero     = in_zero;
                e.rd       = in_rd;
                e.setflags = in_setflags;
                model_q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        wb_ready = 1'b1;
        drive(0, '0, 0, 0, '0, 0);
        tick();
        tick();
        checks++;
        if (count !== '0 || wb_valid !== 1'b0 || flags !== 3'b000 || busy_rd_mask !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: count=%0d wb_valid=%b flags=%b mask=%h, required 0/0/000/00",
                     count, wb_valid, flags, busy_rd_mask);
        end
        checks++;
        if (wb_addr !== '0 || wb_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_wb_port: addr=%0d data=%h, required 0/0000", wb_addr, wb_data);
        end
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single();
        wb_ready = 1'b1;
        drive(1, 16'h1234, 0, 0, 3'd3, 1);
        tick();
        drive(0, '0, 0, 0, '0, 0);
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 3'd3 || wb_data !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL single_latency: valid=%b addr=%0d data=%h, required 1/3/1234",
                     wb_valid, wb_addr, wb_data);
        end
        tick();
        checks++;
        if (flags !== 3'b000 || wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_drain: flags=%b valid=%b, required 000/0", flags, wb_valid);
        end
    endtask

    task automatic test_fill();
        wb_ready = 1'b0;
        drive(1, 16'hAAAA, 0, 0, 3'd1, 0);
        tick();
        drive(1, 16'hBBBB, 0, 0, 3'd5, 0);
        tick();
        checks++;
        if (in_ready !== 1'b0 || count !== 2 || busy_rd_mask !== 8'h22) begin
            errors++;
            $display("[TB] FAIL fill_full: in_ready=%b count=%0d mask=%h, required 0/2/22",
                     in_ready, count, busy_rd_mask);
        end
        drive(1, 16'hCCCC, 0, 0, 3'd7, 0);
        tick();
        drive(0, '0, 0, 0, '0, 0);
        checks++;
        if (count !== 2 || busy_rd_mask !== 8'h22 || wb_addr !== 3'd1 || wb_data !== 16'hAAAA) begin
            errors++;
            $display("[TB] FAIL fill_ignored_push: count=%0d mask=%h addr=%0d data=%h, required 2/22/1/aaaa",
                     count, busy_rd_mask, wb_addr, wb_data);
        end
        wb_ready = 1'b1;
        tick();
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 3'd5 || wb_data !== 16'hBBBB || busy_rd_mask !== 8'h20) begin
            errors++;
            $display("[TB] FAIL fill_order: valid=%b addr=%0d data=%h mask=%h, required 1/5/bbbb/20",
                     wb_valid, wb_addr, wb_data, busy_rd_mask);
        end
        tick();
        checks++;
        if (count !== 0 || wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_empty: count=%0d valid=%b, required 0/0", count, wb_valid);
        end
    endtask

    task automatic test_flags();
        wb_ready = 1'b1;
        drive(1, 16'h0000, 1, 1, 3'd2, 1);
        tick();
        drive(0, '0, 0, 0, '0, 0);
        tick();
        checks++;
        if (flags[1:0] !== 2'b11) begin
            errors++;
            $display("[TB] FAIL flags_set: flags[1:0]=%b, required 11", flags[1:0]);
        end
        drive(1, 16'h8001, 0, 0, 3'd4, 0);
        tick();
        drive(0, '0, 0, 0, '0, 0);
        tick();
        checks++;
        if (flags !== model_flags() || flags[1:0] !== 2'b11) begin
            errors++;
            $display("[TB] FAIL flags_hold: flags=%b, required %b", flags, model_flags());
        end
    endtask

    task automatic test_nflag();
        logic [2:0] want;
`ifdef N_FLAG_EN
        want = 3'b100;
`else
        want = 3'b000;
`endif
        wb_ready = 1'b1;
        drive(1, 16'h8000, 0, 0, 3'd6, 1);
        tick();
        drive(0, '0, 0, 0, '0, 0);
        tick();
        checks++;
        if (flags !== want) begin
            errors++;
            $display("[TB] FAIL n_flag: flags=%b, required %b", flags, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] base;
        base     = DATA_W'($urandom);
        wb_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, base + DATA_W'(i), 0, 0, REG_AW'(i), 0);
            tick();
            checks++;
            if (count !== 1 || wb_valid !== 1'b1 || wb_data !== base + DATA_W'(i) ||
                wb_addr !== REG_AW'(i)) begin
                errors++;
                $display("[TB] FAIL back_to_back[%0d]: count=%0d data=%h addr=%0d, required 1/%h/%0d",
                         i, count, wb_data, wb_addr, base + DATA_W'(i), i % 8);
            end
        end
        drive(0, '0, 0, 0, '0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        wb_ready = 1'b1;
        drive(1, 16'h0001, 1, 1, 3'd0, 1);
        tick();
        drive(0, '0, 0, 0, '0, 0);
        tick();
        wb_ready = 1'b0;
        drive(1, 16'h1111, 0, 0, 3'd2, 0);
        tick();
        drive(1, 16'h2222, 0, 0, 3'd3, 0);
        tick();
        drive(0, '0, 0, 0, '0, 0);
        checks++;
        if (count !== 2 || flags[1:0] !== 2'b11) begin
            errors++;
            $display("[TB] FAIL reset_mid_setup: count=%0d flags=%b, required 2/x11", count, flags);
        end
        wb_ready = 1'b1;
        rst      = 1'b1;
        #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_no_write: wb_valid=%b during reset, required 0", wb_valid);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (count !== 0 || flags !== 3'b000 || busy_rd_mask !== '0 || wb_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_clear: count=%0d flags=%b mask=%h valid=%b, required 0/000/00/0",
                     count, flags, busy_rd_mask, wb_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            wb_ready = 1'($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 2) != 0), DATA_W'($urandom), 1'($urandom), 1'($urandom),
                  REG_AW'($urandom), 1'($urandom));
            checks++;
            if (in_ready !== (model_q.size() < DEPTH)) begin
                errors++;
                $display("[TB] FAIL random_in_ready[%0d]: got %b, required %b",
                         i, in_ready, model_q.size() < DEPTH);
            end
            tick();
            checks++;
            if (count !== model_q.size() || wb_valid !== (model_q.size() != 0) ||
                flags !== model_flags() || busy_rd_mask !== model_mask()) begin
                errors++;
                $display("[TB] FAIL random_state[%0d]: count=%0d valid=%b flags=%b mask=%h, required %0d/%b/%b/%h",
                         i, count, wb_valid, flags, busy_rd_mask, model_q.size(),
                         model_q.size() != 0, model_flags(), model_mask());
            end
            if (model_q.size() != 0) begin
                checks++;
                if (wb_addr !== model_q[0].rd || wb_data !== model_q[0].result) begin
                    errors++;
                    $display("[TB] FAIL random_head[%0d]: addr=%0d data=%h, required %0d/%h",
                             i, wb_addr, wb_data, model_q[0].rd, model_q[0].result);
                end
            end
        end
        drive(0, '0, 0, 0, '0, 0);
        wb_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        wb_ready = 1'b0;
        drive(0, '0, 0, 0, '0, 0);
        model_c  = 0;
        model_z  = 0;
        model_n  = 0;
        test_reset();
        test_single();
        test_fill();
        test_flags();
        test_nflag();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage on the consumer side of the 16-bit add/sub ALU. It accepts one ALU result per cycle with its carry-out, zero flag and destination register index, and holds them in a 2-entry FIFO. It drains entries to the register-file write port under a valid/ready handshake and keeps the architectural status-flag register (C, Z, and N when configured). It sits between the execute stage and the 8-entry, 16-bit register file.

## Interface
Parameters:
- DATA_W, 16, result and write-data width
- REG_AW, 3, register index width (8 registers)
- DEPTH, 2, FIFO entries; must be a power of two, at least 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents a result
- in_ready  out  1  FIFO can accept; asserted when the FIFO is not full
- in_result  in  DATA_W  ALU result
- in_cout  in  1  ALU carry-out
- in_zero  in  1  ALU zero flag
- in_rd  in  REG_AW  destination register
- in_setflags  in  1  entry updates the flag register when it drains
- wb_valid  out  1  head entry presented to the register file
- wb_ready  in  1  register file accepts the write
- wb_addr  out  REG_AW  write address
- wb_data  out  DATA_W  write data
- flags  out  3  {N, Z, C}; N reads 0 when N_FLAG_EN is undefined
- count  out  $clog2(DEPTH)+1  current occupancy
- busy_rd_mask  out  2**REG_AW  one bit per register with a write still pending

## Operation
- Push happens when in_valid and in_ready are both high. The stored entry is {result, cout, zero, rd, setflags}.
- Pop happens when wb_valid and wb_ready are both high. wb_valid equals (count != 0).
- wb_addr and wb_data always show the head entry. They are registered outputs with no combinational path from the in_* inputs.
- Simultaneous push and pop when full:
  - in_ready is low, so the push is not accepted.
  - No bypass from pop to push within the same cycle.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Flag register update on a pop whose entry has setflags set:
  - C takes cout.
  - Z takes zero.
  - N takes result[DATA_W-1] (only when N_FLAG_EN is defined).
- A pop with setflags low leaves the flags unchanged.
- The flag update becomes visible on `flags` the cycle after the pop.
- busy_rd_mask bit r is the OR over valid entries of (rd == r). It is combinational from FIFO state. The hazard unit uses it to stall reads of pending registers.
- Reset values:
  - count 0, pointers 0, wb_valid 0, flags 3'b000, busy_rd_mask 0.
  - wb_addr and wb_data are 0.
  - in_ready is 1 in the cycle after rst deasserts.
- Reset asserted mid-operation:
  - All entries are discarded and the flags are cleared on that edge.
  - No write is issued in the reset cycle, even if wb_ready is high.
- Pushing while in_ready is low is ignored. The upstream stage must hold its data.

## Timing
- Latency from push to wb_valid: 1 cycle when the FIFO is empty (the entry appears on the next edge).
- Throughput: 1 entry per cycle, sustained while wb_ready stays high.
- in_ready = (count != DEPTH). It depends on registered state only.
- wb_valid, wb_addr and wb_data are stable while wb_ready is low. Data must not change until the pop.

## Configuration
- N_FLAG_EN defined:
  - The flag register holds N.
  - flags[2] = result MSB of the last flag-setting entry to drain.
- N_FLAG_EN undefined:
  - No N storage exists.
  - flags[2] is tied to 0.
  - C and Z behave identically in both builds.

## Structure
- Package cpu_pkg holds:
  - DATA_W and REG_AW constants.
  - typedef wb_entry_t {result, cout, zero, rd, setflags}.
  - Flag bit-index constants FLAG_C=0, FLAG_Z=1, FLAG_N=2.
- Sub-module sync_fifo (parameterised by width and depth, with synchronous reset) holds the wb_entry_t storage and the pointers. alu_writeback wraps it with the flag register and the busy-mask logic.

## Test plan
- Reset, then one push of result 0x1234, rd=3, setflags=1, cout=0, zero=0, with wb_ready=1:
  - wb_valid is high the next cycle with wb_addr=3, wb_data=0x1234.
  - flags = 3'b000 after the pop.
- Fill the FIFO with wb_ready=0 (pushes to rd=1 and rd=5):
  - in_ready goes low, count=2, busy_rd_mask=0x22.
  - A third push is ignored.
  - Raising wb_ready then drains the entries in order: rd=1, then rd=5.
- Push result 0x0000, cout=1, zero=1, setflags=1:
  - After the drain, flags[1:0] = 2'b11.
  - A following entry with setflags=0 leaves the flags at 2'b11.
- Push and pop on every cycle for 20 cycles with incrementing data:
  - count stays at 1.
  - Each wb_data equals the value pushed one cycle earlier.
  - The pointers wrap with no loss.
- Assert rst while count=2 and wb_ready=1:
  - No write occurs in that cycle.
  - Next cycle: count=0, flags=0, busy_rd_mask=0.
- N_FLAG_EN build, push 0x8000 with setflags=1:
  - flags[2]=1 after the drain.
  - In the build without N_FLAG_EN the same stimulus gives flags[2]=0.
